queen_solution_checker: RTL and testbench

//  Receive-side consumer of the 8-queen solver's out_bus stream. Captures one board per

---
 rtl/queen_solution_checker_if.sv | 13 +
 rtl/queen_solution_checker.sv | 230 +++++++++++++++++++++++
 tb/tb_queen_solution_checker.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/queen_solution_checker_if.sv
// Row-word stream from the 8-queen solver into the solution checker.
//   in_bus    one row word; bit k set means a queen in column k
//   in_valid  in_bus holds a valid row word
//   in_ready  consumer accepts the word on an edge where in_valid & in_ready
// master = solver side (drives the word), slave = checker side (drives ready).
interface queen_solution_checker_if;
    logic [7:0] in_bus;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_bus, output in_valid, input in_ready);
    modport slave  (input in_bus, input in_valid, output in_ready);
endinterface

// File: rtl/queen_solution_checker.sv
// Downstream self-check and decode stage for the 8-queen solver's board stream.
// Captures eight one-hot row words (row 0 first), decodes each to a column index,
// then re-verifies the placement one queen pair per cycle and reports the verdict.
// Ports:
//   clk             rising-edge clock
//   reset           asynchronous, active-low reset
//   bus             row-word stream (slave side: in_bus, in_valid in; in_ready out)
//   solver_done     solver has emitted its last board
//   result_valid    one-cycle pulse; result_ok / error_code / error_row valid
//   result_ok       board legal
//   error_code      00 ok, 01 not one-hot, 10 column conflict, 11 diagonal conflict
//   error_row       row of the first failure
//   columns         decoded board, column of row r at [3r+2:3r]
//   solution_count  legal boards seen (saturating)
//   error_count     illegal boards seen (saturating)
//   finished        sticky, solver_done accepted
//   partial_drop    sticky, solver_done arrived mid-board
module queen_solution_checker #(
    parameter int COUNT_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    queen_solution_checker_if.slave    bus,
    input  logic                       solver_done,
    output logic                       result_valid,
    output logic                       result_ok,
    output logic [1:0]                 error_code,
    output logic [2:0]                 error_row,
    output logic [23:0]                columns,
    output logic [COUNT_WIDTH-1:0]     solution_count,
    output logic [COUNT_WIDTH-1:0]     error_count,
    output logic                       finished,
    output logic                       partial_drop
);

    typedef enum logic [1:0] {RECV, CHECK, REPORT, FINISHED} state_t;

    // 28 pair cycles followed by one cycle that settles the verdict
    localparam logic [4:0] LAST_STEP = 5'd28;

    state_t      state;
    state_t      next_state;
    logic [2:0]  beat;
    logic [2:0]  col_work [8];
    logic [7:0]  one_hot;
    logic [2:0]  pair_i;
    logic [2:0]  pair_j;
    logic [4:0]  check_step;
    logic        found;
    logic [1:0]  found_code;
    logic [2:0]  found_row;

    logic        accept;
    logic [2:0]  word_col;
    logic        word_one_hot;
    logic [3:0]  col_diff;
    logic [3:0]  row_gap;
    logic        pair_live;
    logic        col_hit;
    logic        diag_hit;
    logic        oh_fail;
    logic [2:0]  oh_fail_row;
    logic [1:0]  final_code;
    logic [2:0]  final_row;
    logic [23:0] cols_packed;

    assign bus.in_ready = (state == RECV) && !solver_done;
    assign accept       = bus.in_valid && bus.in_ready;
    assign result_valid = (state == REPORT);

    // Decode the incoming word: lowest set bit gives the column
    always_comb begin
        word_col = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (bus.in_bus[k]) begin
                word_col = 3'(k);
            end
        end
        word_one_hot = (bus.in_bus != 8'h00) && ((bus.in_bus & (bus.in_bus - 8'h01)) == 8'h00);
    end

    // Pair test: 4-bit absolute difference keeps large gaps from aliasing
    always_comb begin
        col_diff = 4'd0;
        if (col_work[pair_i] > col_work[pair_j]) begin
            col_diff = {1'b0, col_work[pair_i]} - {1'b0, col_work[pair_j]};
        end else begin
            col_diff = {1'b0, col_work[pair_j]} - {1'b0, col_work[pair_i]};
        end
        row_gap   = {1'b0, pair_j} - {1'b0, pair_i};
        pair_live = one_hot[pair_i] && one_hot[pair_j] && (check_step < LAST_STEP);
        col_hit   = pair_live && (col_work[pair_i] == col_work[pair_j]);
        diag_hit  = pair_live && (col_diff == row_gap);
    end

    // Verdict: any bad row word outranks pair conflicts; lowest bad row wins
    always_comb begin
        oh_fail     = (one_hot != 8'hFF);
        oh_fail_row = 3'd0;
        for (int r = 7; r >= 0; r--) begin
            if (!one_hot[r]) begin
                oh_fail_row = 3'(r);
            end
        end
        final_code = 2'b00;
        final_row  = 3'd0;
        if (oh_fail) begin
            final_code = 2'b01;
            final_row  = oh_fail_row;
        end else if (found) begin
            final_code = found_code;
            final_row  = found_row;
        end
        cols_packed = '0;
        for (int r = 0; r < 8; r++) begin
            cols_packed[3*r +: 3] = col_work[r];
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RECV;
        end else begin
            state <= next_state;
        end
    end

    // Next state: solver_done wins over a coincident word while receiving
    always_comb begin
        next_state = state;
        case (state)
            RECV: begin
                if (solver_done) begin
                    next_state = FINISHED;
                end else if (accept && (beat == 3'd7)) begin
                    next_state = CHECK;
                end
            end
            CHECK: begin
                if (check_step == LAST_STEP) begin
                    next_state = REPORT;
                end
            end
            REPORT:   next_state = RECV;
            FINISHED: next_state = FINISHED;
            default:  next_state = RECV;
        endcase
    end

    // Datapath: capture rows, scan pairs, latch the verdict on entry to REPORT
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            beat           <= 3'd0;
            one_hot        <= 8'h00;
            pair_i         <= 3'd0;
            pair_j         <= 3'd1;
            check_step     <= 5'd0;
            found          <= 1'b0;
            found_code     <= 2'b00;
            found_row      <= 3'd0;
            result_ok      <= 1'b0;
            error_code     <= 2'b00;
            error_row      <= 3'd0;
            columns        <= 24'd0;
            solution_count <= '0;
            error_count    <= '0;
            finished       <= 1'b0;
            partial_drop   <= 1'b0;
            for (int r = 0; r < 8; r++) begin
                col_work[r] <= 3'd0;
            end
        end else begin
            case (state)
                RECV: begin
                    if (solver_done) begin
                        finished <= 1'b1;
                        if (beat != 3'd0) begin
                            partial_drop <= 1'b1;
                        end
                        beat <= 3'd0;
                    end else if (accept) begin
                        col_work[beat] <= word_col;
                        one_hot[beat]  <= word_one_hot;
                        beat           <= beat + 3'd1;
                        if (beat == 3'd7) begin
                            pair_i     <= 3'd0;
                            pair_j     <= 3'd1;
                            check_step <= 5'd0;
                            found      <= 1'b0;
                        end
                    end
                end
                CHECK: begin
                    if (check_step < LAST_STEP) begin
                        check_step <= check_step + 5'd1;
                        if (pair_j == 3'd7) begin
                            pair_i <= pair_i + 3'd1;
                            pair_j <= pair_i + 3'd2;
                        end else begin
                            pair_j <= pair_j + 3'd1;
                        end
                        if (!found && (col_hit || diag_hit)) begin
                            found      <= 1'b1;
                            found_code <= col_hit ? 2'b10 : 2'b11;
                            found_row  <= pair_j;
                        end
                    end else begin
                        error_code <= final_code;
                        error_row  <= final_row;
                        result_ok  <= (final_code == 2'b00);
                        columns    <= cols_packed;
                        if (final_code == 2'b00) begin
                            if (solution_count != '1) begin
                                solution_count <= solution_count + 1'b1;
                            end
                        end else begin
                            if (error_count != '1) begin
                                error_count <= error_count + 1'b1;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_queen_solution_checker.sv
// Directed bench for queen_solution_checker: a table of boards with hand-computed
// verdicts, plus sequences for back-pressure, reset mid-check and solver_done cases.
module tb_queen_solution_checker;

    typedef struct {
        logic [0:7][7:0] words;
        logic [1:0]      code;
        logic [2:0]      row;
        logic            check_cols;
        logic [23:0]     cols;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        solver_done = 1'b0;
    logic        result_valid;
    logic        result_ok;
    logic [1:0]  error_code;
    logic [2:0]  error_row;
    logic [23:0] columns;
    logic [7:0]  solution_count;
    logic [7:0]  error_count;
    logic        finished;
    logic        partial_drop;

    int errors = 0;
    int checks = 0;
    int exp_sol = 0;
    int exp_err = 0;
    vec_t vecs [6];

    queen_solution_checker_if bus ();

    always #5 clk = ~clk;

    queen_solution_checker #(.COUNT_WIDTH(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .solver_done    (solver_done),
        .result_valid   (result_valid),
        .result_ok      (result_ok),
        .error_code     (error_code),
        .error_row      (error_row),
        .columns        (columns),
        .solution_count (solution_count),
        .error_count    (error_count),
        .finished       (finished),
        .partial_drop   (partial_drop)
    );

    task check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive rows first..last one per cycle; returns #1 after the last accepting edge
    task apply_stimulus(input logic [0:7][7:0] b, input int first, input int last);
        for (int r = first; r <= last; r++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_bus   = b[r];
            check_output("in_ready_recv", 32'(bus.in_ready), 32'd1);
            @(posedge clk);
        end
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Count edges from the last accept until the pulse is seen on a falling edge
    task wait_result(output int edges);
        logic seen;
        seen  = 1'b0;
        edges = 0;
        while (!seen && edges < 60) begin
            @(negedge clk);
            if (result_valid) begin
                seen = 1'b1;
            end else begin
                @(posedge clk);
                edges++;
            end
        end
    endtask

    task check_counts(input string name);
        check_output({name, "_sol"}, 32'(solution_count), 32'(exp_sol));
        check_output({name, "_err"}, 32'(error_count), 32'(exp_err));
    endtask

    initial begin
        int lat;
        int low;
        int pulses;

        vecs[0] = '{ {8'h01,8'h10,8'h80,8'h20,8'h04,8'h40,8'h02,8'h08}, 2'b00, 3'd0, 1'b1, 24'o31625740 };
        vecs[1] = '{ {8'h80,8'h08,8'h01,8'h04,8'h20,8'h02,8'h40,8'h10}, 2'b00, 3'd0, 1'b1, 24'o46152037 };
        vecs[2] = '{ {8'h08,8'h01,8'h80,8'h02,8'h20,8'h08,8'h04,8'h10}, 2'b10, 3'd5, 1'b0, 24'o0 };
        vecs[3] = '{ {8'h01,8'h02,8'h04,8'h08,8'h10,8'h20,8'h40,8'h80}, 2'b11, 3'd1, 1'b0, 24'o0 };
        vecs[4] = '{ {8'h01,8'h10,8'h00,8'h20,8'h04,8'h40,8'h18,8'h08}, 2'b01, 3'd2, 1'b0, 24'o0 };
        vecs[5] = '{ {8'h01,8'h01,8'h04,8'h08,8'h10,8'h20,8'h40,8'hC0}, 2'b01, 3'd7, 1'b0, 24'o0 };

        bus.in_valid = 1'b0;
        bus.in_bus   = 8'h00;

        // Reset state
        #12;
        check_output("rst_result_valid", 32'(result_valid), 32'd0);
        check_output("rst_result_ok", 32'(result_ok), 32'd0);
        check_output("rst_error_code", 32'(error_code), 32'd0);
        check_output("rst_columns", columns, 32'd0);
        check_output("rst_finished", 32'(finished), 32'd0);
        check_counts("rst");
        @(negedge clk);
        reset = 1'b1;

        // Table of boards
        for (int v = 0; v < 6; v++) begin
            apply_stimulus(vecs[v].words, 0, 7);
            wait_result(lat);
            check_output($sformatf("v%0d_latency", v), 32'(lat), 32'd29);
            check_output($sformatf("v%0d_code", v), 32'(error_code), 32'(vecs[v].code));
            check_output($sformatf("v%0d_ok", v), 32'(result_ok), 32'(vecs[v].code == 2'b00));
            if (vecs[v].code != 2'b00) begin
                check_output($sformatf("v%0d_row", v), 32'(error_row), 32'(vecs[v].row));
            end
            if (vecs[v].check_cols) begin
                check_output($sformatf("v%0d_columns", v), columns, 32'(vecs[v].cols));
            end
            if (vecs[v].code == 2'b00) exp_sol++;
            else exp_err++;
            @(negedge clk);
            check_output($sformatf("v%0d_pulse_width", v), 32'(result_valid), 32'd0);
            check_counts($sformatf("v%0d", v));
        end

        // in_valid held through CHECK and REPORT: ready stays low, held word becomes row 0
        apply_stimulus(vecs[0].words, 0, 7);
        bus.in_valid = 1'b1;
        bus.in_bus   = vecs[1].words[0];
        low = 0;
        while (low < 100) begin
            @(negedge clk);
            if (bus.in_ready) break;
            low++;
        end
        check_output("hold_ready_low_cycles", 32'(low), 32'd30);
        check_output("hold_first_ok", 32'(result_ok), 32'd1);
        check_output("hold_first_columns", columns, 32'(vecs[0].cols));
        exp_sol++;
        @(posedge clk);
        #1;
        apply_stimulus(vecs[1].words, 1, 7);
        wait_result(lat);
        check_output("hold_second_latency", 32'(lat), 32'd29);
        check_output("hold_second_ok", 32'(result_ok), 32'd1);
        check_output("hold_second_columns", columns, 32'(vecs[1].cols));
        exp_sol++;
        @(negedge clk);
        check_counts("hold");

        // Reset in the middle of CHECK: board is lost, no pulse
        apply_stimulus(vecs[0].words, 0, 7);
        repeat (10) @(negedge clk);
        reset = 1'b0;
        #2;
        exp_sol = 0;
        exp_err = 0;
        check_counts("midrst");
        check_output("midrst_columns", columns, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (result_valid) pulses++;
        end
        check_output("midrst_no_pulse", 32'(pulses), 32'd0);

        // solver_done during CHECK: board still reports, then FINISHED without drop
        apply_stimulus(vecs[0].words, 0, 7);
        solver_done = 1'b1;
        wait_result(lat);
        check_output("done_chk_latency", 32'(lat), 32'd29);
        check_output("done_chk_ok", 32'(result_ok), 32'd1);
        exp_sol++;
        repeat (2) @(negedge clk);
        check_output("done_chk_finished", 32'(finished), 32'd1);
        check_output("done_chk_partial", 32'(partial_drop), 32'd0);
        check_counts("done_chk");

        // solver_done after three beats, coincident with in_valid: partial drop
        @(negedge clk);
        reset = 1'b0;
        solver_done = 1'b0;
        exp_sol = 0;
        exp_err = 0;
        @(negedge clk);
        reset = 1'b1;
        apply_stimulus(vecs[0].words, 0, 2);
        bus.in_valid = 1'b1;
        bus.in_bus   = vecs[0].words[3];
        solver_done  = 1'b1;
        @(negedge clk);
        check_output("drop_ready_low", 32'(bus.in_ready), 32'd0);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (result_valid) pulses++;
        end
        check_output("drop_finished", 32'(finished), 32'd1);
        check_output("drop_partial", 32'(partial_drop), 32'd1);
        check_output("drop_no_pulse", 32'(pulses), 32'd0);
        check_counts("drop");

        // Reset clears the sticky flags
        reset = 1'b0;
        #2;
        check_output("clr_finished", 32'(finished), 32'd0);
        check_output("clr_partial", 32'(partial_drop), 32'd0);
        solver_done  = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_output("clr_ready", 32'(bus.in_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
